// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : stopwatch_ctrl                                               |
// | Description : Button conditioning, IDLE/RUN/PAUSE sequencer, count-tick    |
// |               prescaler and lap-hold timer for the stopwatch datapath.     |
// |               Define STOPWATCH_CTRL_DEBOUNCE_EN to include the debouncers. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module stopwatch_ctrl #(
    parameter int TICK_DIV        = 120000,
    parameter int DEBOUNCE_CYCLES = 12000,
    parameter int LAP_HOLD_TICKS  = 200
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       btn_start,
    input  logic       btn_stop,
    input  logic       btn_lap,
    input  logic       btn_clear,
    output logic       tick,
    output logic       count_en,
    output logic       count_clr,
    output logic       lap_capture,
    output logic       show_lap,
    output logic [1:0] state
);
    localparam int c_PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int c_LW = $clog2(LAP_HOLD_TICKS + 1);
    localparam logic [c_PW-1:0] c_PRESC_MAX = c_PW'(TICK_DIV - 1);
    localparam logic [c_LW-1:0] c_LAP_LOAD  = c_LW'(LAP_HOLD_TICKS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10
    } state_t;

    // Button bit order: 0 start, 1 stop, 2 lap, 3 clear
    logic [3:0] w_btn_raw;
    logic [3:0] sync1_q;
    logic [3:0] sync2_q;
    logic [3:0] w_level;
    logic [3:0] prev_q;
    logic [3:0] armed_q;
    logic [3:0] evt_q;

    assign w_btn_raw = {btn_clear, btn_lap, btn_stop, btn_start};

    always_ff @(posedge CLK) begin
        sync1_q <= w_btn_raw;
        sync2_q <= sync1_q;
    end

`ifdef STOPWATCH_CTRL_DEBOUNCE_EN
    localparam int c_DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_DW-1:0] c_DB_LAST = c_DW'(DEBOUNCE_CYCLES - 1);

    for (genvar i = 0; i < 4; i++) begin : g_debounce
        logic [c_DW-1:0] cnt_q;
        logic            lvl_q;

        always_ff @(posedge CLK) begin
            if (!RST_N) begin
                cnt_q <= '0;
                lvl_q <= 1'b0;
            end else if (sync2_q[i] == lvl_q) begin
                cnt_q <= '0;
            end else if (cnt_q == c_DB_LAST) begin
                cnt_q <= '0;
                lvl_q <= sync2_q[i];
            end else begin
                cnt_q <= cnt_q + c_DW'(1);
            end
        end

        assign w_level[i] = lvl_q;
    end
`else
    assign w_level = sync2_q;
`endif

    // A button only generates presses once it has been seen released since
    // reset, so a button held through reset stays silent until re-pressed.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            prev_q  <= '0;
            armed_q <= '0;
            evt_q   <= '0;
        end else begin
            prev_q  <= w_level;
            armed_q <= armed_q | ~sync2_q;
            evt_q   <= w_level & ~prev_q & armed_q;
        end
    end

    logic w_clr_ev;
    logic w_stop_ev;
    logic w_start_ev;
    logic w_lap_ev;

    assign w_clr_ev   = evt_q[3];
    assign w_stop_ev  = evt_q[1] & ~evt_q[3];
    assign w_start_ev = evt_q[0] & ~evt_q[1] & ~evt_q[3];
    assign w_lap_ev   = evt_q[2] & ~evt_q[0] & ~evt_q[1] & ~evt_q[3];

    state_t            state_q;
    state_t            state_d;
    logic              w_restart;
    logic [c_PW-1:0]   presc_q;
    logic [c_PW-1:0]   presc_d;
    logic              w_wrap;
    logic              tick_d;
    logic [c_LW-1:0]   lap_q;
    logic [c_LW-1:0]   lap_d;
    logic              w_lap_take;
    logic              tick_q;
    logic              count_en_q;
    logic              count_clr_q;
    logic              lap_capture_q;
    logic              show_lap_q;

    always_comb begin
        state_d   = state_q;
        w_restart = 1'b0;
        if (w_clr_ev) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_start_ev) begin
                        state_d   = S_RUN;
                        w_restart = 1'b1;
                    end
                end
                S_RUN: begin
                    if (w_stop_ev) state_d = S_PAUSE;
                end
                S_PAUSE: begin
                    if (w_start_ev) begin
                        state_d   = S_RUN;
                        w_restart = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Entering RUN realigns the prescaler so the first count lands a full period later
    always_comb begin
        w_wrap     = (presc_q == c_PRESC_MAX);
        presc_d    = presc_q + c_PW'(1);
        if (w_restart || w_wrap) presc_d = '0;
        tick_d     = w_wrap & ~w_restart;
        w_lap_take = w_lap_ev & (state_q != S_IDLE);
        lap_d      = lap_q;
        if (w_clr_ev) begin
            lap_d = '0;
        end else if (w_lap_take) begin
            lap_d = c_LAP_LOAD;
        end else if (tick_d && (lap_q != '0)) begin
            lap_d = lap_q - c_LW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q       <= S_IDLE;
            presc_q       <= '0;
            lap_q         <= '0;
            tick_q        <= 1'b0;
            count_en_q    <= 1'b0;
            count_clr_q   <= 1'b0;
            lap_capture_q <= 1'b0;
            show_lap_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            presc_q       <= presc_d;
            lap_q         <= lap_d;
            tick_q        <= tick_d;
            count_en_q    <= tick_d & (state_d == S_RUN);
            count_clr_q   <= w_clr_ev;
            lap_capture_q <= w_lap_take;
            show_lap_q    <= (lap_d != '0);
        end
    end

    assign tick        = tick_q;
    assign count_en    = count_en_q;
    assign count_clr   = count_clr_q;
    assign lap_capture = lap_capture_q;
    assign show_lap    = show_lap_q;
    assign state       = state_q;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_stopwatch_ctrl                                            |
// | Description : Randomized self-checking bench for stopwatch_ctrl against a  |
// |               behavioural model, plus directed literal scenarios.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_stopwatch_ctrl;
    localparam int TD   = 10;
    localparam int DB   = 4;
    localparam int HOLD = 3;
`ifdef STOPWATCH_CTRL_DEBOUNCE_EN
    localparam bit DB_EN = 1'b1;
`else
    localparam bit DB_EN = 1'b0;
`endif
    // Pin edge to first registered response
    localparam int LAT = DB_EN ? (2 + DB + 1 + 1) : 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_start, btn_stop, btn_lap, btn_clear;
    logic       tick, count_en, count_clr, lap_capture, show_lap;
    logic [1:0] state;

    stopwatch_ctrl #(
        .TICK_DIV       (TD),
        .DEBOUNCE_CYCLES(DB),
        .LAP_HOLD_TICKS (HOLD)
    ) dut (
        .CLK        (clk),
        .RST_N      (rst_n),
        .btn_start  (btn_start),
        .btn_stop   (btn_stop),
        .btn_lap    (btn_lap),
        .btn_clear  (btn_clear),
        .tick       (tick),
        .count_en   (count_en),
        .count_clr  (count_clr),
        .lap_capture(lap_capture),
        .show_lap   (show_lap),
        .state      (state)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input int act, input int exp_v);
        tests++;
        if (act != exp_v) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
        end
    endtask

    // Behavioural model: pin history, press rules, mode, count anchor, lap hold
    int       cyc = 0;
    bit [3:0] pins [$];
    bit [3:0] m_evt, m_prev, m_armed, m_dbl;
    int       m_run [4];
    int       m_mode, m_anchor, m_lap;
    bit       e_tick, e_en, e_clr, e_cap, e_show;
    int       e_state;

    task automatic model_reset();
        m_mode = 0; m_anchor = cyc; m_lap = 0;
        m_evt = '0; m_prev = '0; m_armed = '0; m_dbl = '0;
        for (int b = 0; b < 4; b++) m_run[b] = 0;
        e_tick = 0; e_en = 0; e_clr = 0; e_cap = 0; e_show = 0; e_state = 0;
    endtask

    task automatic model_step();
        bit [3:0] s;
        bit [3:0] nevt;
        bit       lvl;
        int       ev;
        int       old_mode;
        pins.push_back({btn_clear, btn_lap, btn_stop, btn_start});
        void'(pins.pop_front());
        s = pins[0];  // pin value two edges ago, i.e. the synchronized level
        cyc++;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (m_evt[3])      ev = 1;
        else if (m_evt[1]) ev = 2;
        else if (m_evt[0]) ev = 3;
        else if (m_evt[2]) ev = 4;
        else               ev = 0;
        old_mode = m_mode;
        case (ev)
            1: m_mode = 0;
            2: if (m_mode == 1) m_mode = 2;
            3: if (m_mode != 1) begin m_mode = 1; m_anchor = cyc; end
            default: ;
        endcase
        e_tick = (cyc != m_anchor) && (((cyc - m_anchor) % TD) == 0);
        if (ev == 1)                        m_lap = 0;
        else if (ev == 4 && old_mode != 0)  m_lap = HOLD;
        else if (e_tick && m_lap > 0)       m_lap = m_lap - 1;
        e_en    = e_tick && (m_mode == 1);
        e_clr   = (ev == 1);
        e_cap   = (ev == 4) && (old_mode != 0);
        e_show  = (m_lap > 0);
        e_state = m_mode;
        for (int b = 0; b < 4; b++) begin
            lvl      = DB_EN ? m_dbl[b] : s[b];
            nevt[b]  = lvl & ~m_prev[b] & m_armed[b];
            m_prev[b] = lvl;
            m_armed[b] = m_armed[b] | ~s[b];
            if (DB_EN) begin
                if (s[b] != m_dbl[b]) begin
                    m_run[b]++;
                    if (m_run[b] == DB) begin
                        m_dbl[b] = s[b];
                        m_run[b] = 0;
                    end
                end else begin
                    m_run[b] = 0;
                end
            end
        end
        m_evt = nevt;
    endtask

    initial begin
        pins = '{4'b0, 4'b0, 4'b0};
        model_reset();
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("tick",        tick,        e_tick);
            check("count_en",    count_en,    e_en);
            check("count_clr",   count_clr,   e_clr);
            check("lap_capture", lap_capture, e_cap);
            check("show_lap",    show_lap,    e_show);
            check("state",       state,       e_state);
        end
    end

    task automatic wait_negs(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        btn_start = 0; btn_stop = 0; btn_lap = 0; btn_clear = 0;
        wait_negs(5);
        chk_en = 1'b1;
        rst_n  = 1'b1;
        wait_negs(1);
        check("reset_state", state, 0);
        check("reset_outs", {tick, count_en, count_clr, lap_capture, show_lap}, 0);

        // start held: RUN appears exactly LAT cycles after the pin edge
        btn_start = 1;
        wait_negs(LAT - 1);
        check("start_early_state", state, 0);
        check("start_early_model", e_state, 0);
        wait_negs(1);
        check("start_state", state, 1);
        check("start_model", e_state, 1);
        wait_negs(TD - 1);
        check("first_en_early", count_en, 0);
        wait_negs(1);
        check("first_en", count_en, 1);
        check("first_en_model", e_en, 1);
        btn_start = 0;
        wait_negs(15);

        // lap in RUN: capture then hold for three ticks
        btn_lap = 1;
        wait_negs(LAT);
        check("lap_capture", lap_capture, 1);
        check("lap_show", show_lap, 1);
        btn_lap = 0;
        wait_negs(4 * TD);
        check("lap_expired", show_lap, 0);

        // clear and stop together: clear wins, no PAUSE
        btn_clear = 1; btn_stop = 1;
        wait_negs(LAT - 1);
        check("clr_before", state, 1);
        wait_negs(1);
        check("clr_pulse", count_clr, 1);
        check("clr_state", state, 0);
        check("clr_model", e_clr, 1);
        wait_negs(1);
        check("clr_one_cycle", count_clr, 0);
        btn_clear = 0; btn_stop = 0;
        wait_negs(15);

`ifdef STOPWATCH_CTRL_DEBOUNCE_EN
        // bounce shorter than the debounce window produces nothing
        btn_start = 1;
        wait_negs(3);
        btn_start = 0;
        wait_negs(20);
        check("bounce_state", state, 0);
`endif

        // reset mid-RUN while show_lap is high, buttons held through reset
        btn_start = 1;
        wait_negs(LAT + 2);
        btn_start = 0;
        wait_negs(12);
        btn_lap = 1;
        wait_negs(LAT);
        check("pre_rst_show", show_lap, 1);
        btn_start = 1;
        wait_negs(3);
        rst_n = 1'b0;
        wait_negs(1);
        rst_n = 1'b1;
        check("rst_mid_state", state, 0);
        check("rst_mid_outs", {tick, count_en, count_clr, lap_capture, show_lap}, 0);
        wait_negs(25);
        check("held_no_event", state, 0);
        btn_start = 0; btn_lap = 0;
        wait_negs(15);

        // randomized phase
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(7) == 0)  btn_start = ~btn_start;
            if ($urandom_range(9) == 0)  btn_stop  = ~btn_stop;
            if ($urandom_range(6) == 0)  btn_lap   = ~btn_lap;
            if ($urandom_range(24) == 0) btn_clear = ~btn_clear;
            rst_n = ($urandom_range(799) != 0);
            wait_negs(1);
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
